// File: rtl/dvb_s2_bch_pkg.sv
// Shared constants for the DVB-S2 BCH encoders.
// The short-frame t=12 generator is built at elaboration from its twelve minimal factors.
package dvb_s2_bch_pkg;

    localparam int PAR_W_SHORT     = 168;
    localparam int K_BCH_SHORT_MIN = 3072;
    localparam int K_BCH_SHORT_MAX = 14232;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } bch_state_e;

    // Minimal polynomials g1..g12 over GF(2^14), bit i = coefficient of x^i
    function automatic logic [14:0] g_factor(input int i);
        logic [14:0] g;
        case (i)
            0:       g = 15'h402B;
            1:       g = 15'h4941;
            2:       g = 15'h4647;
            3:       g = 15'h5591;
            4:       g = 15'h6B55;
            5:       g = 15'h6389;
            6:       g = 15'h6CE5;
            7:       g = 15'h4F21;
            8:       g = 15'h460F;
            9:       g = 15'h5A49;
            10:      g = 15'h5811;
            default: g = 15'h65EF;
        endcase
        return g;
    endfunction

    function automatic logic [167:0] gen_short_t12();
        logic [168:0] p;
        logic [168:0] r;
        logic [14:0]  g;
        p = 169'd1;
        for (int i = 0; i < 12; i++) begin
            r = '0;
            g = g_factor(i);
            for (int b = 0; b < 15; b++) begin
                if (g[b]) r = r ^ (p << b);
            end
            p = r;
        end
        return p[167:0];
    endfunction

    localparam logic [167:0] G_SHORT_T12 = gen_short_t12();

endpackage

// File: rtl/bch_short_t12_encoder_lfsr.sv
// Serial BCH remainder register: clear, shift with or without feedback.
// Clear and shift together start a new remainder from the incoming bit.
module bch_lfsr_serial #(
    parameter int             W    = 168,
    parameter logic [W-1:0]   POLY = '0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic shift_i,
    input  logic fb_en_i,
    input  logic din_i,
    output logic msb_o
);

    logic [W-1:0] lfsr_q, lfsr_d, base;
    logic         fb;

    always_comb begin
        base   = clr_i ? '0 : lfsr_q;
        fb     = fb_en_i & (din_i ^ base[W-1]);
        lfsr_d = base;
        if (shift_i) lfsr_d = {base[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= '0;
        else       lfsr_q <= lfsr_d;
    end

    assign msb_o = lfsr_q[W-1];

endmodule

// File: rtl/bch_short_t12_encoder.sv
// DVB-S2 short-frame BCH (t=12) serial encoder: forwards K_bch data bits,
// then appends 168 parity bits MSB first through one registered output stage.
module bch_short_t12_encoder
    import dvb_s2_bch_pkg::*;
#(
    parameter int PAR_W = 168,
    parameter int KW    = 14
) (
    input  logic          clk_1x,
    input  logic          rst,
    input  logic [KW-1:0] k_bch,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_data,
    input  logic          in_sof,
    input  logic          in_eof,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_data,
    output logic          out_sof,
    output logic          out_eof,
    output logic          out_is_par,
    output logic          err_len
);

    bch_state_e    state_q, state_d;
    logic [KW-1:0] k_q, k_d, cnt_q, cnt_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic          ov_q, ov_d, od_q, od_d, sof_q, sof_d;
    logic          eof_q, eof_d, par_q, par_d, err_q, err_d;
    logic          adv, acc, k_ok, last;
    logic          l_clr, l_shift, l_fb, l_msb;

    bch_lfsr_serial #(
        .W    (PAR_W),
        .POLY (G_SHORT_T12)
    ) u_lfsr (
        .clk_i   (clk_1x),
        .rst_i   (rst),
        .clr_i   (l_clr),
        .shift_i (l_shift),
        .fb_en_i (l_fb),
        .din_i   (in_data),
        .msb_o   (l_msb)
    );

    always_comb begin
        adv      = ~ov_q | out_ready;
        in_ready = ~rst & (state_q != PARITY) & adv;
        acc      = in_valid & in_ready;
        k_ok     = (k_bch >= KW'(K_BCH_SHORT_MIN)) &&
                   (k_bch <= KW'(K_BCH_SHORT_MAX));
        last     = (cnt_q + KW'(1)) == k_q;
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        pcnt_d   = pcnt_q;
        ov_d     = ov_q;
        od_d     = od_q;
        sof_d    = sof_q;
        eof_d    = eof_q;
        par_d    = par_q;
        err_d    = 1'b0;
        l_clr    = 1'b0;
        l_shift  = 1'b0;
        l_fb     = 1'b0;
        if (adv) begin
            ov_d  = 1'b0;
            od_d  = 1'b0;
            sof_d = 1'b0;
            eof_d = 1'b0;
            par_d = 1'b0;
        end
        if (acc && in_sof) begin
            // A start always restarts; an out-of-range length drops the frame
            err_d = ~k_ok | in_eof | (state_q == DATA);
            if (k_ok) begin
                state_d = DATA;
                k_d     = k_bch;
                cnt_d   = KW'(1);
                l_clr   = 1'b1;
                l_shift = 1'b1;
                l_fb    = 1'b1;
                ov_d    = 1'b1;
                od_d    = in_data;
                sof_d   = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else if (acc && state_q == DATA) begin
            cnt_d   = cnt_q + KW'(1);
            l_shift = 1'b1;
            l_fb    = 1'b1;
            ov_d    = 1'b1;
            od_d    = in_data;
            err_d   = in_eof ^ last;
            if (last) begin
                state_d = PARITY;
                pcnt_d  = '0;
            end
        end else if (state_q == PARITY && adv) begin
            ov_d    = 1'b1;
            od_d    = l_msb;
            par_d   = 1'b1;
            eof_d   = pcnt_q == 8'(PAR_W - 1);
            l_shift = 1'b1;
            pcnt_d  = pcnt_q + 8'd1;
            if (pcnt_q == 8'(PAR_W - 1)) state_d = IDLE;
        end
    end

    always_ff @(posedge clk_1x or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            ov_q    <= 1'b0;
            od_q    <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            par_q   <= par_d;
            err_q   <= err_d;
        end
    end

    assign out_valid  = ov_q;
    assign out_data   = od_q;
    assign out_sof    = sof_q;
    assign out_eof    = eof_q;
    assign out_is_par = par_q;
    assign err_len    = err_q;

endmodule

// File: tb/tb_bch_short_t12_encoder.sv
// Bench for bch_short_t12_encoder: long-division reference model, random
// data and backpressure, length-error and mid-parity reset scenarios.
module tb_bch_short_t12_encoder;

    logic        clk_1x = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] k_bch = '0;
    logic        in_valid = 1'b0, in_data = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, out_data, out_sof, out_eof, out_is_par, err_len;

    always #5 clk_1x = ~clk_1x;

    bch_short_t12_encoder dut (
        .clk_1x     (clk_1x),
        .rst        (rst),
        .k_bch      (k_bch),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .in_eof     (in_eof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .out_is_par (out_is_par),
        .err_len    (err_len)
    );

    int          n_chk = 0, n_pass = 0;
    bit          gfull [169];
    bit          dbits [14232];
    bit          pbits [168];
    bit          w     [14400];
    logic [3:0]  exp_q [$];
    logic [3:0]  mon_e;
    int          rx_cnt = 0, par_rx = 0, err_cnt = 0, low_cnt = 0;
    bit          rand_ready = 1'b0;
    bit          abort = 1'b0;

    function automatic void chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    // Generator = product of the twelve minimal polynomials, as coefficient array
    function automatic void build_g();
        int gm [12] = '{'h402B, 'h4941, 'h4647, 'h5591, 'h6B55, 'h6389,
                        'h6CE5, 'h4F21, 'h460F, 'h5A49, 'h5811, 'h65EF};
        bit nw [169];
        int deg = 0;
        foreach (gfull[i]) gfull[i] = 1'b0;
        gfull[0] = 1'b1;
        for (int f = 0; f < 12; f++) begin
            foreach (nw[i]) nw[i] = 1'b0;
            for (int a = 0; a <= deg; a++)
                if (gfull[a])
                    for (int b = 0; b < 15; b++)
                        if (gm[f][b]) nw[a+b] = nw[a+b] ^ 1'b1;
            deg += 14;
            foreach (gfull[i]) gfull[i] = nw[i];
        end
    endfunction

    // Remainder of m(x)*x^168 / g(x); first data bit is the highest power
    function automatic void model(int k);
        for (int i = 0; i < k; i++) w[i] = dbits[i];
        for (int i = 0; i < 168; i++) w[k+i] = 1'b0;
        for (int i = 0; i < k; i++)
            if (w[i])
                for (int j = 0; j <= 168; j++) w[i+j] = w[i+j] ^ gfull[168-j];
        for (int t = 0; t < 168; t++) pbits[t] = w[k+t];
    endfunction

    initial forever begin
        @(posedge clk_1x);
        #1;
        out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
    end

    always @(negedge clk_1x) begin
        if (!rst) begin
            if (err_len) err_cnt++;
            if (!in_ready) low_cnt++;
            if (out_valid && out_ready) begin
                rx_cnt++;
                if (out_is_par) par_rx++;
                if (exp_q.size() == 0) chk("extra output bit", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("stream bit %0d {d,sof,eof,par}", rx_cnt - 1),
                        {out_data, out_sof, out_eof, out_is_par}, mon_e);
                end
            end
        end
    end

    task automatic drive_bit(input bit d, input bit s, input bit e);
        bit seen;
        bit got;
        if (abort) return;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        in_eof   = e;
        got      = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_1x);
            seen = in_ready;
            @(posedge clk_1x);
            #1;
            if (seen) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("in_ready timeout", 0, 1);
            abort = 1'b1;
        end
    endtask

    // mode 0: all zero, 1: single one at last data bit, 2: random
    task automatic send_frame(input int k, input int mode, input int extra_eof);
        for (int i = 0; i < k; i++)
            dbits[i] = (mode == 2) ? 1'($urandom % 2) : ((mode == 1) && (i == k - 1));
        model(k);
        for (int i = 0; i < k; i++)
            exp_q.push_back({dbits[i], (i == 0) ? 1'b1 : 1'b0, 2'b00});
        for (int t = 0; t < 168; t++)
            exp_q.push_back({pbits[t], 1'b0, (t == 167) ? 1'b1 : 1'b0, 1'b1});
        k_bch = 14'(k);
        for (int i = 0; i < k; i++)
            drive_bit(dbits[i], i == 0, (i == k - 1) || (i == extra_eof));
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk_1x);
            if (exp_q.size() == 0) break;
        end
        repeat (6) @(posedge clk_1x);
        #1;
        chk({nm, " drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, r0, p0, ones, diff;

        build_g();
        chk("g has x^168", gfull[168], 1);
        chk("g has x^0", gfull[0], 1);
        foreach (dbits[i]) dbits[i] = 1'b0;
        model(3072);
        ones = 0;
        foreach (pbits[t]) ones += pbits[t];
        chk("model zero msg parity weight", ones, 0);
        dbits[3071] = 1'b1;
        model(3072);
        diff = 0;
        foreach (pbits[t]) diff += (pbits[t] != gfull[167-t]);
        chk("model single-one parity is g", diff, 0);

        in_valid = 1'b1;
        in_sof   = 1'b1;
        repeat (3) @(posedge clk_1x);
        #1;
        chk("in reset outputs",
            {in_ready, out_valid, out_data, out_sof, out_eof, out_is_par, err_len}, 0);
        go_idle();
        @(posedge clk_1x);
        #1;
        rst = 1'b0;
        #1;
        chk("after reset outputs",
            {in_ready, out_valid, out_data, out_sof, out_eof, out_is_par, err_len}, 7'b1000000);

        e0 = err_cnt; r0 = rx_cnt; p0 = par_rx; low_cnt = 0;
        send_frame(3072, 0, -1);
        go_idle();
        drain("zero frame");
        chk("zero frame bit count", rx_cnt - r0, 3240);
        chk("zero frame parity count", par_rx - p0, 168);
        chk("zero frame in_ready low cycles", low_cnt, 168);
        chk("zero frame err_len", err_cnt - e0, 0);

        send_frame(3072, 1, -1);
        go_idle();
        drain("single-one frame");

        r0 = rx_cnt;
        send_frame(14232, 2, -1);
        go_idle();
        drain("k14232 frame");
        chk("k14232 bit count", rx_cnt - r0, 14400);

        rand_ready = 1'b1;
        e0 = err_cnt; r0 = rx_cnt;
        send_frame(5232, 2, -1);
        send_frame(7032, 2, -1);
        send_frame(3072, 2, -1);
        go_idle();
        drain("back-to-back");
        rand_ready = 1'b0;
        chk("back-to-back bit count", rx_cnt - r0, 5400 + 7200 + 3240);
        chk("back-to-back err_len", err_cnt - e0, 0);

        e0 = err_cnt; r0 = rx_cnt;
        send_frame(3072, 2, 3070);
        go_idle();
        drain("early eof frame");
        chk("early eof err_len pulses", err_cnt - e0, 1);
        chk("early eof bit count", rx_cnt - r0, 3240);

        e0 = err_cnt; r0 = rx_cnt;
        k_bch = 14'd3000;
        drive_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'($urandom % 2), 1'b0, 1'b0);
        go_idle();
        repeat (5) @(posedge clk_1x);
        #1;
        chk("bad k err_len pulses", err_cnt - e0, 1);
        chk("bad k no output", rx_cnt - r0, 0);
        send_frame(3072, 2, -1);
        go_idle();
        drain("after bad k frame");
        chk("after bad k bit count", rx_cnt - r0, 3240);

        p0 = par_rx;
        send_frame(3072, 2, -1);
        go_idle();
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk_1x);
            if (par_rx - p0 >= 50) break;
        end
        chk("reached parity bit 50", (par_rx - p0 >= 50) ? 1 : 0, 1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid-parity reset outputs",
            {in_ready, out_valid, out_data, out_sof, out_eof, out_is_par, err_len}, 0);
        repeat (3) @(posedge clk_1x);
        #1;
        rst = 1'b0;
        r0 = rx_cnt;
        send_frame(3072, 2, -1);
        go_idle();
        drain("post-reset frame");
        chk("post-reset bit count", rx_cnt - r0, 3240);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bch_short_t12_encoder.md
Name: bch_short_t12_encoder

Overview:
DVB-S2 short-frame BCH encoder (t=12, 168 parity bits). It accepts the BBFRAME bit stream one bit per clock and passes the K_bch data bits through unchanged. It then appends the 168-bit BCH parity serially, MSB first, producing N_bch = K_bch + 168 bits. Sits between the BB scrambler and the LDPC encoder in the kc705_dvb_s2 transmit chain.

Parameters:
PAR_W, 168, parity length in bits (fixed for short t=12).
KW, 14, width of k_bch port.

Ports:
clk_1x  in  1  system clock
rst  in  1  asynchronous active-high reset
k_bch  in  KW  data bits per frame; sampled on accepted in_sof; legal range 3072..14232
in_valid  in  1  input bit valid
in_ready  out  1  input accept
in_data  in  1  input bit
in_sof  in  1  first data bit of frame
in_eof  in  1  last data bit of frame
out_valid  out  1  output bit valid
out_ready  in  1  downstream accept
out_data  out  1  output bit (data, then parity)
out_sof  out  1  first bit of codeword
out_eof  out  1  last parity bit
out_is_par  out  1  high on parity bits
err_len  out  1  one-cycle pulse on frame-length violation

Behaviour:
- Reset (async, rst=1): state=IDLE, lfsr=0, counters=0, every output 0, in_ready=0 while rst asserted.
- Single registered output stage. Latency in→out is 1 cycle.
- Transfer occurs on valid&ready. Output register advances when ~out_valid | out_ready.
- in_ready = (state!=PARITY) & (~out_valid | out_ready).
- IDLE: input bits without in_sof are dropped (accepted, not forwarded). An accepted bit with in_sof latches k_bch, clears lfsr, sets cnt=1, emits the bit with out_sof=1, and goes to DATA. If k_bch is outside 3072..14232, pulse err_len and stay IDLE.
- DATA: each accepted bit uses fb = in_data ^ lfsr[167]; lfsr <= {lfsr[166:0],0} ^ (fb ? G_SHORT_T12 : 0). The bit is forwarded and cnt increments.
- When cnt reaches k_bch (the last data bit accepted), go to PARITY with pcnt=0. If in_eof≠(cnt==k_bch), pulse err_len, but the count still governs.
- In-frame in_sof (cnt<k_bch): pulse err_len, restart the frame from that bit; the partial codeword is abandoned without parity.
- PARITY: on each output advance, out_data=lfsr[167], lfsr shifts left filling 0, out_is_par=1. out_eof=1 on pcnt=167, after which state returns to IDLE. in_ready=0 throughout PARITY (168 cycles minimum).
- out_ready low holds out_* stable. Nothing is lost or duplicated under any backpressure pattern.
- Back-to-back frames: the next frame's in_sof is accepted on the cycle after the last parity bit is loaded.
- Simultaneous in_sof and in_eof are illegal for the legal k_bch range: pulse err_len and treat the bit as a normal sof.

Decomposition:
- Package dvb_s2_bch_pkg: G_SHORT_T12 (168-bit generator polynomial, x^168 term implicit, product of g1..g12 per EN 302 307 Table 6b), PAR_W_SHORT=168, K_BCH_SHORT_MIN=3072, K_BCH_SHORT_MAX=14232, state enum {IDLE,DATA,PARITY}.
- One sub-module: bch_lfsr_serial (168-bit LFSR with load/clear/shift and feedback enable), reusable for normal-frame t=8/10/12.

Test Plan:
- All-zero frame, k_bch=3072, out_ready=1: 3240 output bits, all 168 parity bits 0, out_sof on bit 0, out_eof on bit 3239, in_ready low exactly 168 cycles.
- k_bch=3072, single 1 at data bit 3071: parity equals G_SHORT_T12 MSB first. Random frame at k_bch=14232: parity matches the software polynomial-division model bit-exact.
- Random out_ready (50% duty) over 3 back-to-back random frames with k_bch=5232, 7032, 3072: output equals the model stream, with no gaps in content, no drop and no duplicate.
- in_eof asserted at bit 3070 with k_bch=3072: err_len pulses once, parity is still emitted after bit 3071.
- k_bch=3000 on sof: err_len pulse, no output, state stays IDLE. A subsequent valid frame encodes correctly.
- Assert rst mid-PARITY (pcnt=50): outputs are 0 immediately. After release, a new frame encodes correctly with lfsr cleared.
